// File: rtl/exc_oldest_tracker.sv
// exc_oldest_tracker
//   Collects exception reports from the writeback ports and holds the single
//   oldest excepting instruction (robIdx, cause, tval) for commit/trap logic.
//   Age order uses the robIdx flipped bit (MSB) plus the index bits.
// Ports:
//   clk, rst          core clock, synchronous active-high reset
//   i_exc_*           per-port exception report (valid, robIdx, cause, tval)
//   i_squash(_robIdx) drop everything strictly younger than i_squash_robIdx
//   i_flush_all       global flush, ignores all inputs this cycle
//   i_ack             commit consumed the held exception
//   o_exc_*           held exception; data keeps last value when o_exc_vld=0
//   o_exc_cnt         saturating count of accepted (post-squash) reports
module exc_oldest_tracker #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned ROB_SIZE  = 64,
  parameter int unsigned TVAL_W    = 64,
  localparam int unsigned RW       = 1 + $clog2(ROB_SIZE)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             i_exc_vld,
  input  logic [NUM_PORTS-1:0][RW-1:0]     i_exc_robIdx,
  input  logic [NUM_PORTS-1:0][15:0]       i_exc_cause,
  input  logic [NUM_PORTS-1:0][TVAL_W-1:0] i_exc_tval,
  input  logic                             i_squash,
  input  logic [RW-1:0]                    i_squash_robIdx,
  input  logic                             i_flush_all,
  input  logic                             i_ack,
  output logic                             o_exc_vld,
  output logic [RW-1:0]                    o_exc_robIdx,
  output logic [15:0]                      o_exc_cause,
  output logic [TVAL_W-1:0]                o_exc_tval,
  output logic [31:0]                      o_exc_cnt
);

  typedef enum logic {IDLE, HELD} state_t;

  state_t state, state_nxt;

  logic              sel_vld;
  logic [RW-1:0]     sel_idx;
  logic [15:0]       sel_cause;
  logic [TVAL_W-1:0] sel_tval;
  logic [NUM_PORTS-1:0] surv;
  logic [31:0]       nsurv;
  logic [32:0]       cnt_sum;
  logic              load;
  logic              held_live;

  // a older than b; differing flipped bits mean b has wrapped, so larger idx is older.
  function automatic logic older(input logic [RW-1:0] a, input logic [RW-1:0] b);
    if (a[RW-1] == b[RW-1]) return a[RW-2:0] < b[RW-2:0];
    else                    return a[RW-2:0] > b[RW-2:0];
  endfunction

  // Squash filter + oldest select; strict compare keeps the lowest port on ties.
  always_comb begin
    sel_vld   = 1'b0;
    sel_idx   = '0;
    sel_cause = '0;
    sel_tval  = '0;
    surv      = '0;
    nsurv     = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      surv[p] = i_exc_vld[p] && !(i_squash && older(i_squash_robIdx, i_exc_robIdx[p]));
      if (surv[p]) begin
        nsurv = nsurv + 32'd1;
        if (!sel_vld || older(i_exc_robIdx[p], sel_idx)) begin
          sel_vld   = 1'b1;
          sel_idx   = i_exc_robIdx[p];
          sel_cause = i_exc_cause[p];
          sel_tval  = i_exc_tval[p];
        end
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and capture enable
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    held_live = (state == HELD) && !(i_squash && older(i_squash_robIdx, o_exc_robIdx));
    if (i_flush_all) begin
      state_nxt = IDLE;
    end else if (i_ack && state == HELD) begin
      load      = sel_vld;
      state_nxt = sel_vld ? HELD : IDLE;
    end else if (!held_live) begin
      // Covers IDLE and a held entry killed by squash: both reduce to a fresh merge.
      load      = sel_vld;
      state_nxt = sel_vld ? HELD : IDLE;
    end else begin
      load      = sel_vld && older(sel_idx, o_exc_robIdx);
      state_nxt = HELD;
    end
  end

  // Outputs
  always_comb begin
    o_exc_vld = (state == HELD);
  end

  assign cnt_sum = {1'b0, o_exc_cnt} + {1'b0, nsurv};

  always_ff @(posedge clk) begin
    if (rst) begin
      o_exc_robIdx <= '0;
      o_exc_cause  <= '0;
      o_exc_tval   <= '0;
      o_exc_cnt    <= '0;
    end else begin
      if (load) begin
        o_exc_robIdx <= sel_idx;
        o_exc_cause  <= sel_cause;
        o_exc_tval   <= sel_tval;
      end
      if (!i_flush_all)
        o_exc_cnt <= cnt_sum[32] ? '1 : cnt_sum[31:0];
    end
  end

endmodule

// File: tb/tb_exc_oldest_tracker.sv
module tb_exc_oldest_tracker;

  localparam int unsigned NP = 4;
  localparam int unsigned RW = 7;
  localparam int unsigned TW = 64;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NP-1:0]            i_exc_vld;
  logic [NP-1:0][RW-1:0]    i_exc_robIdx;
  logic [NP-1:0][15:0]      i_exc_cause;
  logic [NP-1:0][TW-1:0]    i_exc_tval;
  logic                     i_squash;
  logic [RW-1:0]            i_squash_robIdx;
  logic                     i_flush_all;
  logic                     i_ack;
  logic                     o_exc_vld;
  logic [RW-1:0]            o_exc_robIdx;
  logic [15:0]              o_exc_cause;
  logic [TW-1:0]            o_exc_tval;
  logic [31:0]              o_exc_cnt;

  exc_oldest_tracker #(.NUM_PORTS(NP), .ROB_SIZE(64), .TVAL_W(TW)) dut (
    .clk(clk), .rst(rst),
    .i_exc_vld(i_exc_vld), .i_exc_robIdx(i_exc_robIdx),
    .i_exc_cause(i_exc_cause), .i_exc_tval(i_exc_tval),
    .i_squash(i_squash), .i_squash_robIdx(i_squash_robIdx),
    .i_flush_all(i_flush_all), .i_ack(i_ack),
    .o_exc_vld(o_exc_vld), .o_exc_robIdx(o_exc_robIdx),
    .o_exc_cause(o_exc_cause), .o_exc_tval(o_exc_tval),
    .o_exc_cnt(o_exc_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic                  rst;
    logic [NP-1:0]         vld;
    logic [NP-1:0][RW-1:0] idx;
    logic [NP-1:0][15:0]   cause;
    logic [NP-1:0][TW-1:0] tval;
    logic                  squash;
    logic [RW-1:0]         sq_idx;
    logic                  flush;
    logic                  ack;
    logic                  e_vld;
    logic [RW-1:0]         e_idx;
    logic [15:0]           e_cause;
    logic [TW-1:0]         e_tval;
    logic [31:0]           e_cnt;
  } vec_t;

  vec_t tbl[$];
  vec_t v;
  int   checks = 0;
  int   passes = 0;

  function automatic logic [RW-1:0] ri(input logic f, input int unsigned i);
    logic [31:0] t;
    t = i;
    return {f, t[5:0]};
  endfunction

  task automatic port(inout vec_t x, input int unsigned p, input logic [RW-1:0] idx,
                      input logic [15:0] c, input logic [TW-1:0] t);
    x.vld[p]   = 1'b1;
    x.idx[p]   = idx;
    x.cause[p] = c;
    x.tval[p]  = t;
  endtask

  task automatic expect_(inout vec_t x, input logic ev, input logic [RW-1:0] ei,
                         input logic [15:0] ec, input logic [TW-1:0] et, input logic [31:0] en);
    x.e_vld = ev; x.e_idx = ei; x.e_cause = ec; x.e_tval = et; x.e_cnt = en;
  endtask

  task automatic chk(input int n, input string what, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL v%0d %s got=%0h exp=%0h", n, what, got, exp);
  endtask

  initial begin
    rst = 1'b1; i_exc_vld = '0; i_exc_robIdx = '0; i_exc_cause = '0; i_exc_tval = '0;
    i_squash = 1'b0; i_squash_robIdx = '0; i_flush_all = 1'b0; i_ack = 1'b0;

    // 0: reset
    v = '0; v.rst = 1'b1; expect_(v, 0, '0, 16'd0, 64'd0, 0); tbl.push_back(v);
    // 1: idle, nothing
    v = '0; expect_(v, 0, '0, 16'd0, 64'd0, 0); tbl.push_back(v);
    // 2: single report on port 1
    v = '0; port(v, 1, ri(0, 5), 16'd5, 64'h1000);
    expect_(v, 1, ri(0, 5), 16'd5, 64'h1000, 1); tbl.push_back(v);
    // 3: reset while HELD
    v = '0; v.rst = 1'b1; expect_(v, 0, '0, 16'd0, 64'd0, 0); tbl.push_back(v);
    // 4: three ports, tie on {0,7}: port 2 wins
    v = '0; port(v, 0, ri(0, 20), 16'd2, 64'h20); port(v, 2, ri(0, 7), 16'd13, 64'h70);
    port(v, 3, ri(0, 7), 16'd15, 64'h71);
    expect_(v, 1, ri(0, 7), 16'd13, 64'h70, 3); tbl.push_back(v);
    // 5: flush, data retained
    v = '0; v.flush = 1'b1; expect_(v, 0, ri(0, 7), 16'd13, 64'h70, 3); tbl.push_back(v);
    // 6..10: wrap-around ordering
    v = '0; port(v, 0, ri(0, 62), 16'd1, 64'hA); expect_(v, 1, ri(0, 62), 16'd1, 64'hA, 4); tbl.push_back(v);
    v = '0; port(v, 0, ri(1, 2), 16'd2, 64'hB);  expect_(v, 1, ri(0, 62), 16'd1, 64'hA, 5); tbl.push_back(v);
    v = '0; v.flush = 1'b1; expect_(v, 0, ri(0, 62), 16'd1, 64'hA, 5); tbl.push_back(v);
    v = '0; port(v, 0, ri(1, 2), 16'd2, 64'hB);  expect_(v, 1, ri(1, 2), 16'd2, 64'hB, 6); tbl.push_back(v);
    v = '0; port(v, 0, ri(0, 62), 16'd1, 64'hA); expect_(v, 1, ri(0, 62), 16'd1, 64'hA, 7); tbl.push_back(v);
    // 11: flush
    v = '0; v.flush = 1'b1; expect_(v, 0, ri(0, 62), 16'd1, 64'hA, 7); tbl.push_back(v);
    // 12: hold {0,30}
    v = '0; port(v, 0, ri(0, 30), 16'd3, 64'h30); expect_(v, 1, ri(0, 30), 16'd3, 64'h30, 8); tbl.push_back(v);
    // 13: squash at {0,10} kills held and port1 {0,12}; squashed port not counted
    v = '0; v.squash = 1'b1; v.sq_idx = ri(0, 10); port(v, 1, ri(0, 12), 16'd4, 64'h12);
    expect_(v, 0, ri(0, 30), 16'd3, 64'h30, 8); tbl.push_back(v);
    // 14: hold {0,30} again
    v = '0; port(v, 0, ri(0, 30), 16'd3, 64'h30); expect_(v, 1, ri(0, 30), 16'd3, 64'h30, 9); tbl.push_back(v);
    // 15: squash at {0,30}: held equal survives, port1 {0,31} dropped
    v = '0; v.squash = 1'b1; v.sq_idx = ri(0, 30); port(v, 1, ri(0, 31), 16'd4, 64'h31);
    expect_(v, 1, ri(0, 30), 16'd3, 64'h30, 9); tbl.push_back(v);
    // 16: squash at {0,30}: older survivor {0,12} replaces held
    v = '0; v.squash = 1'b1; v.sq_idx = ri(0, 30); port(v, 1, ri(0, 12), 16'd4, 64'h12);
    expect_(v, 1, ri(0, 12), 16'd4, 64'h12, 10); tbl.push_back(v);
    // 17: flush
    v = '0; v.flush = 1'b1; expect_(v, 0, ri(0, 12), 16'd4, 64'h12, 10); tbl.push_back(v);
    // 18: hold {0,4}
    v = '0; port(v, 0, ri(0, 4), 16'd6, 64'h4); expect_(v, 1, ri(0, 4), 16'd6, 64'h4, 11); tbl.push_back(v);
    // 19: ack with younger port3 {0,9}: captured
    v = '0; v.ack = 1'b1; port(v, 3, ri(0, 9), 16'd7, 64'h9);
    expect_(v, 1, ri(0, 9), 16'd7, 64'h9, 12); tbl.push_back(v);
    // 20: ack, nothing incoming -> IDLE
    v = '0; v.ack = 1'b1; expect_(v, 0, ri(0, 9), 16'd7, 64'h9, 12); tbl.push_back(v);
    // 21: ack in IDLE with input: ack ignored, merge captures
    v = '0; v.ack = 1'b1; port(v, 2, ri(0, 4), 16'd6, 64'h4);
    expect_(v, 1, ri(0, 4), 16'd6, 64'h4, 13); tbl.push_back(v);
    // 22: flush with port0 {0,1}: ignored, count unchanged
    v = '0; v.flush = 1'b1; port(v, 0, ri(0, 1), 16'd1, 64'h1);
    expect_(v, 0, ri(0, 4), 16'd6, 64'h4, 13); tbl.push_back(v);
    // 23: flush priority over ack
    v = '0; port(v, 1, ri(1, 0), 16'd8, 64'h80); expect_(v, 1, ri(1, 0), 16'd8, 64'h80, 14); tbl.push_back(v);
    v = '0; v.flush = 1'b1; v.ack = 1'b1; port(v, 0, ri(1, 1), 16'd9, 64'h81);
    expect_(v, 0, ri(1, 0), 16'd8, 64'h80, 14); tbl.push_back(v);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst = tbl[i].rst; i_exc_vld = tbl[i].vld; i_exc_robIdx = tbl[i].idx;
      i_exc_cause = tbl[i].cause; i_exc_tval = tbl[i].tval;
      i_squash = tbl[i].squash; i_squash_robIdx = tbl[i].sq_idx;
      i_flush_all = tbl[i].flush; i_ack = tbl[i].ack;
      @(posedge clk);
      #1;
      chk(i, "vld",   {63'd0, o_exc_vld},      {63'd0, tbl[i].e_vld});
      chk(i, "robIdx", {57'd0, o_exc_robIdx},  {57'd0, tbl[i].e_idx});
      chk(i, "cause", {48'd0, o_exc_cause},    {48'd0, tbl[i].e_cause});
      chk(i, "tval",  o_exc_tval,              tbl[i].e_tval);
      chk(i, "cnt",   {32'd0, o_exc_cnt},      {32'd0, tbl[i].e_cnt});
    end

    // Hand sequence: outputs must not follow inputs within the same cycle.
    @(negedge clk);
    rst = 1'b0; i_exc_vld = '0; i_squash = 1'b0; i_flush_all = 1'b0; i_ack = 1'b0;
    i_exc_vld[0] = 1'b1; i_exc_robIdx[0] = ri(0, 3); i_exc_cause[0] = 16'd11; i_exc_tval[0] = 64'hDEAD;
    #2;
    chk(100, "no_comb_vld", {63'd0, o_exc_vld}, 64'd0);
    @(posedge clk); #1;
    chk(100, "lat_vld", {63'd0, o_exc_vld}, 64'd1);
    chk(100, "lat_robIdx", {57'd0, o_exc_robIdx}, {57'd0, ri(0, 3)});
    chk(100, "lat_cnt", {32'd0, o_exc_cnt}, 64'd15);

    // Hand sequence: squash across flipped boundary. Held {0,3}; squash at {1,60}
    // (older than {0,3}? no: differing flips, 60 > 3 so {1,60} is older) kills it,
    // port1 {1,61} is younger than {1,60} and is dropped too.
    @(negedge clk);
    i_exc_vld = '0; i_squash = 1'b1; i_squash_robIdx = ri(1, 60);
    i_exc_vld[1] = 1'b1; i_exc_robIdx[1] = ri(1, 61);
    @(posedge clk); #1;
    chk(101, "wrap_sq_vld", {63'd0, o_exc_vld}, 64'd0);
    chk(101, "wrap_sq_cnt", {32'd0, o_exc_cnt}, 64'd15);

    @(negedge clk);
    i_exc_vld = '0; i_squash = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/exc_oldest_tracker.md
Name: exc_oldest_tracker

Overview:
- Collects exception reports from the execute/writeback ports and holds the single oldest excepting instruction: robIdx, mcause code and tval.
- Sits between the writeback ports and the ROB commit/trap logic.
- Commit reads its output to raise the trap when the held robIdx reaches the ROB head.
- Age ordering uses the robIdx_t flipped bit plus the index.

Parameters:
- NUM_PORTS, 4, number of writeback ports that can report exceptions per cycle
- ROB_SIZE, 64, ROB depth (power of two); robIdx width = 1 + clog2(ROB_SIZE)
- TVAL_W, 64, width of the trap value

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- i_exc_vld  in  NUM_PORTS  per-port exception report valid
- i_exc_robIdx  in  NUM_PORTS x robIdx_t  reporting instruction's robIdx
- i_exc_cause  in  NUM_PORTS x 16  rv_trap_t::exception code
- i_exc_tval  in  NUM_PORTS x TVAL_W  faulting address or instruction bits
- i_squash  in  1  partial squash (branch mispredict)
- i_squash_robIdx  in  robIdx_t  squash every entry strictly younger than this robIdx
- i_flush_all  in  1  global flush (trap taken, fence, etc.)
- i_ack  in  1  commit consumed the held exception
- o_exc_vld  out  1  an exception is held
- o_exc_robIdx  out  robIdx_t  held robIdx
- o_exc_cause  out  16  held cause
- o_exc_tval  out  TVAL_W  held tval
- o_exc_cnt  out  32  count of accepted reports, saturating

Behaviour:
- Reset: o_exc_vld=0, o_exc_robIdx=0, o_exc_cause=0, o_exc_tval=0, o_exc_cnt=0. The FSM goes to IDLE.
- Age rule: A is older than B iff (A.flipped==B.flipped) ? A.idx<B.idx : A.idx>B.idx. Equal robIdx counts as not older.
- Input select (combinational):
  - Among valid ports, choose the oldest.
  - On ties (equal robIdx), the lowest port number wins.
  - When i_squash=1, first drop every port whose robIdx is strictly younger than i_squash_robIdx.
- FSM states: IDLE (nothing held), HELD (o_exc_vld=1).
- Per-cycle priority: rst > i_flush_all > i_ack > i_squash > merge.
  - i_flush_all: go to IDLE and ignore all inputs this cycle. o_exc_cnt is not incremented.
  - i_ack while HELD: the held entry is cleared. A selected input in the same cycle is captured and the FSM stays HELD; otherwise it goes to IDLE. i_ack in IDLE is ignored.
  - i_squash while HELD and the held robIdx is strictly younger than i_squash_robIdx: the held entry is invalidated, then merged with the filtered inputs. A held robIdx equal to i_squash_robIdx survives.
  - Merge in IDLE: if a selected input exists, capture it and go to HELD.
  - Merge in HELD: replace the held entry only if the selected input is strictly older. Otherwise keep it.
- Latency: a report in cycle N is visible on the outputs in cycle N+1. No combinational path from inputs to outputs.
- o_exc_robIdx/cause/tval keep their last values when o_exc_vld=0.
- o_exc_cnt:
  - Increments by the number of valid ports that survive the squash filter in cycles without i_flush_all, whether or not they win.
  - Saturates at 0xFFFFFFFF.
  - Cleared only by rst.
- Wrap-around: age comparison must be correct across the flipped boundary, e.g. {1,2} is older than {0,62}? No: with differing flipped bits, the larger idx is older, so {0,62} is older than {1,2}.
- No input backpressure: reports are never dropped except by squash, flush or age loss.

Test Plan:
- Reset, then port1 reports robIdx {0,5}, cause 5 (loadFault), tval 0x1000 -> next cycle o_exc_vld=1, robIdx {0,5}, cause 5, tval 0x1000, o_exc_cnt=1.
- Ports 0,2,3 report {0,20},{0,7},{0,7} with causes 2,13,15 in the same cycle -> held {0,7} cause 13 (port 2 wins the tie), o_exc_cnt=3.
- Holding {0,62}, port0 reports {1,2} -> held entry stays {0,62}. Holding {1,2}, port0 reports {0,62} -> held entry is replaced by {0,62}.
- Holding {0,30}, i_squash with i_squash_robIdx {0,10} while port1 reports {0,12} -> {0,30} and {0,12} both squashed, o_exc_vld=0. Repeat with i_squash_robIdx {0,30} -> {0,30} held.
- Holding {0,4}, i_ack with port3 reporting {0,9} cause 7 -> next cycle held {0,9} cause 7, o_exc_vld=1.
- Holding {0,4}, i_flush_all with port0 reporting {0,1} -> o_exc_vld=0 and o_exc_cnt unchanged. Asserting rst mid-HELD -> all outputs 0 on the next cycle.
